int_dispatch_queue: RTL and testbench

//  In-order integer dispatch queue between rename/dispatch and the execution block.

---
 rtl/int_dispatch_queue.sv | 131 +++++++++++++
 tb/tb_int_dispatch_queue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/int_dispatch_queue.sv
// In-order integer dispatch queue: compacting multi-lane enqueue, prefix dequeue, full flush on squash.

package int_dispatch_queue_pkg;

  // Renamed integer uop as held in the dispatch queue
  typedef struct packed {
    logic [5:0] rob_idx;
    logic [6:0] pdst;
    logic [6:0] psrc1;
    logic [6:0] psrc2;
    logic [4:0] opcode;
  } intDQEntry_t;

endpackage

module int_dispatch_queue
  import int_dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ENQ_WID = 4,
  parameter int unsigned DEQ_WID = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_squash_vld,
  output logic                             o_enq_rdy,
  input  logic        [ENQ_WID-1:0]        i_enq_vld,
  input  intDQEntry_t [ENQ_WID-1:0]        i_enq_info,
  output logic        [DEQ_WID-1:0]        o_deq_req,
  output intDQEntry_t [DEQ_WID-1:0]        o_deq_info,
  input  logic        [DEQ_WID-1:0]        i_deq_vld,
  output logic        [$clog2(DEPTH):0]    o_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [PTR_W-1:0]   count_q, count_d;
  logic               enq_rdy_q, enq_rdy_d;
  logic [DEQ_WID-1:0] deq_req_q, deq_req_d;

  intDQEntry_t        ram_q [DEPTH];

  logic [ENQ_WID-1:0] wr_en;
  logic [IDX_W-1:0]   wr_idx [ENQ_WID];
  logic [PTR_W-1:0]   enq_n;
  logic [PTR_W-1:0]   deq_n;
  logic               deq_run;

  // Compact valid enqueue lanes onto consecutive slots starting at tail
  always_comb begin
    wr_en = '0;
    enq_n = '0;
    for (int l = 0; l < int'(ENQ_WID); l++) begin
      wr_idx[l] = tail_q[IDX_W-1:0] + enq_n[IDX_W-1:0];
      if (enq_rdy_q && !i_squash_vld && i_enq_vld[l]) begin
        wr_en[l] = 1'b1;
        enq_n    = enq_n + PTR_W'(1);
      end
    end
  end

  // Dequeue count is the unbroken run of accepted valid lanes from lane 0
  always_comb begin
    deq_n   = '0;
    deq_run = 1'b1;
    for (int k = 0; k < int'(DEQ_WID); k++) begin
      if (deq_run && i_deq_vld[k] && deq_req_q[k]) begin
        deq_n = deq_n + PTR_W'(1);
      end else begin
        deq_run = 1'b0;
      end
    end
  end

  // Next pointers/occupancy; squash wins over any enqueue or dequeue
  always_comb begin
    head_d  = head_q + deq_n;
    tail_d  = tail_q + enq_n;
    count_d = count_q + enq_n - deq_n;
    if (i_squash_vld) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    enq_rdy_d = (PTR_W'(DEPTH) - count_d) >= PTR_W'(ENQ_WID);
    for (int k = 0; k < int'(DEQ_WID); k++) begin
      deq_req_d[k] = count_d > PTR_W'(k);
    end
  end

  // Control state, with ready/request flags precomputed from next occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      enq_rdy_q <= 1'b1;
      deq_req_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      enq_rdy_q <= enq_rdy_d;
      deq_req_q <= deq_req_d;
    end
  end

  // Payload storage; never cleared, validity tracked by count alone
  always_ff @(posedge clk) begin
    for (int l = 0; l < int'(ENQ_WID); l++) begin
      if (wr_en[l]) begin
        ram_q[wr_idx[l]] <= i_enq_info[l];
      end
    end
  end

  // Combinational read of the oldest DEQ_WID slots
  always_comb begin
    for (int k = 0; k < int'(DEQ_WID); k++) begin
      o_deq_info[k] = ram_q[IDX_W'(head_q[IDX_W-1:0] + IDX_W'(k))];
    end
  end

  assign o_enq_rdy = enq_rdy_q;
  assign o_deq_req = deq_req_q;
  assign o_count   = count_q;

endmodule

// File: tb/tb_int_dispatch_queue.sv
// Directed self-checking bench for int_dispatch_queue (DEPTH=16, ENQ_WID=4, DEQ_WID=4).

module tb_int_dispatch_queue;
  import int_dispatch_queue_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      i_squash_vld;
  logic                      o_enq_rdy;
  logic        [3:0]         i_enq_vld;
  intDQEntry_t [3:0]         i_enq_info;
  logic        [3:0]         o_deq_req;
  intDQEntry_t [3:0]         o_deq_info;
  logic        [3:0]         i_deq_vld;
  logic        [4:0]         o_count;

  int n_pass  = 0;
  int n_total = 0;

  int_dispatch_queue #(.DEPTH(16), .ENQ_WID(4), .DEQ_WID(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_squash_vld (i_squash_vld),
    .o_enq_rdy    (o_enq_rdy),
    .i_enq_vld    (i_enq_vld),
    .i_enq_info   (i_enq_info),
    .o_deq_req    (o_deq_req),
    .o_deq_info   (o_deq_info),
    .i_deq_vld    (i_deq_vld),
    .o_count      (o_count)
  );

  always #5 clk = ~clk;

  function automatic intDQEntry_t mk(input int t);
    intDQEntry_t e;
    e.rob_idx = 6'(t);
    e.pdst    = 7'(t + 1);
    e.psrc1   = 7'(t * 3);
    e.psrc2   = 7'(t + 64);
    e.opcode  = 5'(t ^ 21);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grp(input int base);
    i_enq_vld = 4'hf;
    for (int l = 0; l < 4; l++) i_enq_info[l] = mk(base + l);
  endtask

  task automatic idle();
    i_enq_vld = 4'h0;
    i_deq_vld = 4'h0;
    i_squash_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    for (int l = 0; l < 4; l++) i_enq_info[l] = mk(200);
    #12;
    // Reset state
    chk("rst_deq_req", 64'(o_deq_req), 64'h0);
    chk("rst_count",   64'(o_count),   64'd0);
    chk("rst_enq_rdy", 64'(o_enq_rdy), 64'd1);
    tick();
    rst = 1'b1;

    // Fill: 4 per cycle, no dequeue
    grp(0); tick();
    chk("fill_cnt4", 64'(o_count), 64'd4);
    chk("fill_req4", 64'(o_deq_req), 64'hf);
    chk("fill_lane0", 64'(o_deq_info[0]), 64'(mk(0)));
    grp(4); tick();
    chk("fill_cnt8", 64'(o_count), 64'd8);
    grp(8); tick();
    chk("fill_cnt12", 64'(o_count), 64'd12);
    chk("fill_rdy12", 64'(o_enq_rdy), 64'd1);
    grp(12); tick();
    chk("fill_cnt16", 64'(o_count), 64'd16);
    chk("fill_rdy16", 64'(o_enq_rdy), 64'd0);
    // Fifth group at full must be dropped
    grp(100); tick();
    chk("full_cnt", 64'(o_count), 64'd16);
    chk("full_lane0", 64'(o_deq_info[0]), 64'(mk(0)));

    // Prefix dequeue: lanes 0,1 accepted, hole at lane 2
    i_enq_vld = 4'h0;
    i_deq_vld = 4'b1011; tick();
    chk("pfx_cnt", 64'(o_count), 64'd14);
    chk("pfx_lane0", 64'(o_deq_info[0]), 64'(mk(2)));
    chk("pfx_lane1", 64'(o_deq_info[1]), 64'(mk(3)));
    chk("pfx_rdy14", 64'(o_enq_rdy), 64'd0);
    // Drain 14 -> 10 -> 6 -> 2
    i_deq_vld = 4'hf; tick();
    chk("drn_lane0", 64'(o_deq_info[0]), 64'(mk(6)));
    tick(); tick();
    chk("drn_cnt2", 64'(o_count), 64'd2);
    chk("drn_req2", 64'(o_deq_req), 64'b0011);
    chk("drn_l0", 64'(o_deq_info[0]), 64'(mk(14)));
    chk("drn_l1", 64'(o_deq_info[1]), 64'(mk(15)));
    tick();
    chk("empty_cnt", 64'(o_count), 64'd0);
    chk("empty_req", 64'(o_deq_req), 64'h0);

    // Sparse enqueue: lanes 1 and 3 compact into two consecutive slots
    idle();
    i_enq_vld = 4'b1010;
    i_enq_info[0] = mk(99); i_enq_info[1] = mk(40);
    i_enq_info[2] = mk(99); i_enq_info[3] = mk(41);
    #2;
    chk("nobypass_req", 64'(o_deq_req), 64'h0);
    tick();
    chk("sp_req", 64'(o_deq_req), 64'b0011);
    chk("sp_cnt", 64'(o_count), 64'd2);
    chk("sp_l0", 64'(o_deq_info[0]), 64'(mk(40)));
    chk("sp_l1", 64'(o_deq_info[1]), 64'(mk(41)));

    // Walk head to index 14: drain 2, then 12 in and 12 out
    idle(); i_deq_vld = 4'hf; tick();
    idle();
    grp(50); tick(); grp(54); tick(); grp(58); tick();
    chk("walk_cnt12", 64'(o_count), 64'd12);
    idle(); i_deq_vld = 4'hf; tick(); tick(); tick();
    chk("walk_cnt0", 64'(o_count), 64'd0);
    idle();
    grp(70); tick();
    chk("wrap_pre_l0", 64'(o_deq_info[0]), 64'(mk(70)));
    chk("wrap_pre_l3", 64'(o_deq_info[3]), 64'(mk(73)));

    // Wrap: enqueue 4 and dequeue 2 in the same cycle at head=14
    grp(74); i_deq_vld = 4'b0011; tick();
    chk("wrap_cnt", 64'(o_count), 64'd6);
    chk("wrap_l0", 64'(o_deq_info[0]), 64'(mk(72)));
    chk("wrap_l1", 64'(o_deq_info[1]), 64'(mk(73)));
    chk("wrap_l2", 64'(o_deq_info[2]), 64'(mk(74)));
    chk("wrap_l3", 64'(o_deq_info[3]), 64'(mk(75)));
    idle(); i_deq_vld = 4'hf; tick();
    chk("wrap_tail_cnt", 64'(o_count), 64'd2);
    chk("wrap_tail_l0", 64'(o_deq_info[0]), 64'(mk(76)));
    chk("wrap_tail_l1", 64'(o_deq_info[1]), 64'(mk(77)));

    // Squash at count 10 with simultaneous enq 4 / deq 2
    idle();
    grp(80); tick(); grp(84); tick();
    chk("sq_pre_cnt", 64'(o_count), 64'd10);
    grp(90); i_deq_vld = 4'b0011; i_squash_vld = 1'b1; tick();
    chk("sq_cnt", 64'(o_count), 64'd0);
    chk("sq_req", 64'(o_deq_req), 64'h0);
    chk("sq_rdy", 64'(o_enq_rdy), 64'd1);
    idle();
    i_enq_vld = 4'b0001; i_enq_info[0] = mk(95); tick();
    chk("sq_post_req", 64'(o_deq_req), 64'b0001);
    chk("sq_post_l0", 64'(o_deq_info[0]), 64'(mk(95)));

    // Asynchronous reset in the middle of traffic
    grp(110); tick();
    chk("mid_cnt", 64'(o_count), 64'd5);
    #2 rst = 1'b0;
    #1;
    chk("arst_req", 64'(o_deq_req), 64'h0);
    chk("arst_cnt", 64'(o_count), 64'd0);
    chk("arst_rdy", 64'(o_enq_rdy), 64'd1);
    idle();
    tick();
    rst = 1'b1;
    i_enq_vld = 4'b0001; i_enq_info[0] = mk(120); tick();
    idle();
    chk("arst_post_cnt", 64'(o_count), 64'd1);
    chk("arst_post_l0", 64'(o_deq_info[0]), 64'(mk(120)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
